// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: operand forwarding,
// multi-bubble load-use stalls, data-memory freeze and a saturating stall counter.
module hazard_fwd_ctrl #(
    parameter int REG_W            = 4,
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int ZERO_REG         = 1,
    parameter int CNT_W            = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] ID_RegRs,
    input  logic [REG_W-1:0] ID_RegRt,
    input  logic             ID_MemWrite,
    input  logic [REG_W-1:0] EX_RegRs,
    input  logic [REG_W-1:0] EX_RegRt,
    input  logic [REG_W-1:0] EX_RegRd,
    input  logic             EX_MemRead,
    input  logic [REG_W-1:0] MEM_RegRd,
    input  logic [REG_W-1:0] MEM_RegRt,
    input  logic             MEM_RegWrite,
    input  logic             MEM_MemWrite,
    input  logic [REG_W-1:0] WB_RegRd,
    input  logic             WB_RegWrite,
    input  logic             mem_busy,
    input  logic             cnt_clr,
    output logic [1:0]       Forward_A,
    output logic [1:0]       Forward_B,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             stall_idex,
    output logic             stall_exmem,
    output logic             flush_idex,
    output logic             flush_memwb,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic {RUN, BUBBLE} state_t;

    localparam logic [1:0]       BUB_INIT = 2'(LOAD_USE_BUBBLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    // With a single bubble the store-data path is covered by the MEM->MEM forward.
    localparam bit STORE_EXEMPT = (LOAD_USE_BUBBLES == 1);

    state_t     state;
    logic [1:0] bub_cnt;
    logic       ex_a, wb_a, ex_b, wb_b, mm_b, lu;

    function automatic logic match(input logic [REG_W-1:0] x, input logic [REG_W-1:0] y);
        return (x == y) && !(ZERO_REG != 0 && x == '0);
    endfunction

    always_comb begin
        ex_a = MEM_RegWrite && match(MEM_RegRd, EX_RegRs);
        wb_a = WB_RegWrite  && match(WB_RegRd, EX_RegRs);
        ex_b = MEM_RegWrite && match(MEM_RegRd, EX_RegRt);
        wb_b = WB_RegWrite  && match(WB_RegRd, EX_RegRt);
        mm_b = MEM_MemWrite && WB_RegWrite && match(WB_RegRd, MEM_RegRt);
        Forward_A = ex_a ? 2'b10 : wb_a ? 2'b01 : 2'b00;
        Forward_B = mm_b ? 2'b11 : ex_b ? 2'b10 : wb_b ? 2'b01 : 2'b00;
        lu = EX_MemRead && (match(EX_RegRd, ID_RegRs) ||
                            (match(EX_RegRd, ID_RegRt) && !(ID_MemWrite && STORE_EXEMPT)));
    end

    always_comb begin
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        stall_idex  = 1'b0;
        stall_exmem = 1'b0;
        flush_idex  = 1'b0;
        flush_memwb = 1'b0;
        if (!rst) begin
            if (mem_busy) begin
                stall_pc    = 1'b1;
                stall_ifid  = 1'b1;
                stall_idex  = 1'b1;
                stall_exmem = 1'b1;
                flush_memwb = 1'b1;
            end else if (state == BUBBLE || lu) begin
                stall_pc   = 1'b1;
                stall_ifid = 1'b1;
                flush_idex = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            bub_cnt      <= 2'd0;
            stall_cycles <= '0;
        end else begin
            // A frozen cycle holds the sequence; bubbles are only consumed while memory runs.
            if (!mem_busy) begin
                if (state == RUN) begin
                    if (lu && LOAD_USE_BUBBLES > 1) begin
                        state   <= BUBBLE;
                        bub_cnt <= BUB_INIT;
                    end
                end else begin
                    bub_cnt <= bub_cnt - 2'd1;
                    if (bub_cnt == 2'd1) state <= RUN;
                end
            end
            if (cnt_clr)
                stall_cycles <= '0;
            else if (stall_pc && stall_cycles != '1)
                stall_cycles <= stall_cycles + CNT_ONE;
        end
    end

endmodule
